// File: rtl/pwr_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwr_seq_pkg
// Brief    : Shared state encoding, defaults and per-state output table for
//            the power-switch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pwr_seq_pkg;

  localparam int c_DEFAULT_STEP_DELAY  = 2;
  localparam int c_DEFAULT_ACK_TIMEOUT = 64;

  typedef enum logic [3:0] {
    ST_ON          = 4'd0,
    ST_CLK_OFF     = 4'd1,
    ST_ISO_ON      = 4'd2,
    ST_RST_ON      = 4'd3,
    ST_SW_OFF_WAIT = 4'd4,
    ST_OFF         = 4'd5,
    ST_SW_ON_WAIT  = 4'd6,
    ST_RST_OFF     = 4'd7,
    ST_ISO_OFF     = 4'd8,
    ST_CLK_ON      = 4'd9,
    ST_FAULT       = 4'd10
  } pwr_state_e;

  typedef struct packed {
    logic switch_no;
    logic iso_no;
    logic rst_no;
    logic clk_en;
  } pwr_out_t;

  // FAULT has no entry of its own: it keeps whatever the previous state drove.
  function automatic pwr_out_t state_outputs(input pwr_state_e st);
    pwr_out_t o;
    o = '{switch_no: 1'b0, iso_no: 1'b1, rst_no: 1'b1, clk_en: 1'b1};
    case (st)
      ST_CLK_OFF: o.clk_en = 1'b0;
      ST_ISO_ON: begin
        o.clk_en = 1'b0;
        o.iso_no = 1'b0;
      end
      ST_RST_ON, ST_SW_ON_WAIT: begin
        o.clk_en = 1'b0;
        o.iso_no = 1'b0;
        o.rst_no = 1'b0;
      end
      ST_SW_OFF_WAIT, ST_OFF: begin
        o.clk_en    = 1'b0;
        o.iso_no    = 1'b0;
        o.rst_no    = 1'b0;
        o.switch_no = 1'b1;
      end
      ST_RST_OFF: begin
        o.clk_en = 1'b0;
        o.iso_no = 1'b0;
      end
      ST_ISO_OFF: o.clk_en = 1'b0;
      default: ;
    endcase
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwr_seq_ack_sync.sv
`default_nettype none
// ============================================================================
// Module   : pwr_seq_ack_sync
// Brief    : Two-flop synchronizer for the asynchronous switch acknowledge.
// Revision : 1.0 - initial release
// ============================================================================
module pwr_seq_ack_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule
`default_nettype wire

// File: rtl/pwr_switch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pwr_switch_sequencer
// Brief    : Power-domain sequencer: clock gate, isolation, reset and power
//            switch stepped in order, with acknowledge timeout to FAULT.
// Revision : 1.0 - initial release
// ============================================================================
module pwr_switch_sequencer
  import pwr_seq_pkg::*;
#(
  parameter int STEP_DELAY  = c_DEFAULT_STEP_DELAY,
  parameter int ACK_TIMEOUT = c_DEFAULT_ACK_TIMEOUT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       power_off_req_i,
  input  logic       wakeup_i,
  input  logic       switch_ack_ni,
  output logic       switch_no,
  output logic       iso_no,
  output logic       subsys_rst_no,
  output logic       clk_en_o,
  output logic       busy_o,
  output logic       err_o,
  output logic [3:0] state_o
);

  localparam int c_STEP_W = $clog2(STEP_DELAY) + 1;
  localparam int c_TMO_W  = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(STEP_DELAY - 1);
  localparam logic [c_TMO_W-1:0]  c_TMO_LAST  = c_TMO_W'(ACK_TIMEOUT - 1);

  pwr_state_e          r_state;
  pwr_state_e          w_state_nxt;
  pwr_out_t            r_out;
  logic [c_STEP_W-1:0] r_step_cnt;
  logic [c_TMO_W-1:0]  r_wait_cnt;
  logic                w_ack_s;
  logic                w_step_done;
  logic                w_tmo;

  pwr_seq_ack_sync u_ack_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (switch_ack_ni),
    .q_o    (w_ack_s)
  );

  assign w_step_done = (r_step_cnt == c_STEP_LAST);
  assign w_tmo       = (r_wait_cnt == c_TMO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ON:          if (power_off_req_i) w_state_nxt = ST_CLK_OFF;
      ST_CLK_OFF:     if (w_step_done) w_state_nxt = ST_ISO_ON;
      ST_ISO_ON:      if (w_step_done) w_state_nxt = ST_RST_ON;
      ST_RST_ON:      if (w_step_done) w_state_nxt = ST_SW_OFF_WAIT;
      ST_SW_OFF_WAIT: begin
        if (w_ack_s)    w_state_nxt = ST_OFF;
        else if (w_tmo) w_state_nxt = ST_FAULT;
      end
      ST_OFF:         if (wakeup_i) w_state_nxt = ST_SW_ON_WAIT;
      ST_SW_ON_WAIT: begin
        if (!w_ack_s)   w_state_nxt = ST_RST_OFF;
        else if (w_tmo) w_state_nxt = ST_FAULT;
      end
      ST_RST_OFF:     if (w_step_done) w_state_nxt = ST_ISO_OFF;
      ST_ISO_OFF:     if (w_step_done) w_state_nxt = ST_CLK_ON;
      ST_CLK_ON:      if (w_step_done) w_state_nxt = ST_ON;
      ST_FAULT:       w_state_nxt = ST_FAULT;
      default:        w_state_nxt = ST_FAULT;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_o;
  // entering FAULT simply stops updating them.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= ST_ON;
      r_out      <= state_outputs(ST_ON);
      r_step_cnt <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != ST_FAULT) begin
        r_out <= state_outputs(w_state_nxt);
      end
      if (w_state_nxt != r_state) begin
        r_step_cnt <= '0;
        r_wait_cnt <= '0;
      end else begin
        if (r_step_cnt != '1) r_step_cnt <= r_step_cnt + 1'b1;
        if (r_wait_cnt != '1) r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

  assign switch_no     = r_out.switch_no;
  assign iso_no        = r_out.iso_no;
  assign subsys_rst_no = r_out.rst_no;
  assign clk_en_o      = r_out.clk_en;
  assign busy_o        = !(r_state inside {ST_ON, ST_OFF, ST_FAULT});
  assign err_o         = (r_state == ST_FAULT);
  assign state_o       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pwr_switch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwr_switch_sequencer
// Brief    : Directed self-checking bench for pwr_switch_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwr_switch_sequencer;

  localparam logic [3:0] S_ON = 4'd0, S_CLK_OFF = 4'd1, S_ISO_ON = 4'd2,
                         S_RST_ON = 4'd3, S_SW_OFF_WAIT = 4'd4, S_OFF = 4'd5,
                         S_SW_ON_WAIT = 4'd6, S_RST_OFF = 4'd7, S_ISO_OFF = 4'd8,
                         S_CLK_ON = 4'd9, S_FAULT = 4'd10;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       power_off_req_i;
  logic       wakeup_i;
  logic       switch_ack_ni;
  logic       switch_no, iso_no, subsys_rst_no, clk_en_o, busy_o, err_o;
  logic [3:0] state_o;
  logic [9:0] obs;
  logic [15:0] ack_pipe = '0;
  logic       force_ack0 = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk_i = ~clk_i;

  // Switch model: ack follows switch_no 16 cycles later (captured mid-cycle).
  always @(negedge clk_i) ack_pipe <= {ack_pipe[14:0], switch_no};
  assign switch_ack_ni = force_ack0 ? 1'b0 : ack_pipe[15];

  assign obs = {state_o, switch_no, iso_no, subsys_rst_no, clk_en_o, busy_o, err_o};

  pwr_switch_sequencer #(.STEP_DELAY(2), .ACK_TIMEOUT(32)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .power_off_req_i (power_off_req_i),
    .wakeup_i        (wakeup_i),
    .switch_ack_ni   (switch_ack_ni),
    .switch_no       (switch_no),
    .iso_no          (iso_no),
    .subsys_rst_no   (subsys_rst_no),
    .clk_en_o        (clk_en_o),
    .busy_o          (busy_o),
    .err_o           (err_o),
    .state_o         (state_o)
  );

  // {state, switch_no, iso_no, subsys_rst_no, clk_en, busy, err}; FAULT entry
  // assumes it was reached from SW_OFF_WAIT.
  function automatic logic [9:0] exp_vec(input logic [3:0] st);
    logic [5:0] o;
    case (st)
      S_ON:          o = 6'b0_1_1_1_0_0;
      S_CLK_OFF:     o = 6'b0_1_1_0_1_0;
      S_ISO_ON:      o = 6'b0_0_1_0_1_0;
      S_RST_ON:      o = 6'b0_0_0_0_1_0;
      S_SW_OFF_WAIT: o = 6'b1_0_0_0_1_0;
      S_OFF:         o = 6'b1_0_0_0_0_0;
      S_SW_ON_WAIT:  o = 6'b0_0_0_0_1_0;
      S_RST_OFF:     o = 6'b0_0_1_0_1_0;
      S_ISO_OFF:     o = 6'b0_1_1_0_1_0;
      S_CLK_ON:      o = 6'b0_1_1_1_1_0;
      default:       o = 6'b1_0_0_0_0_1;
    endcase
    return {st, o};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic test_reset;
    rst_ni = 1'b0; power_off_req_i = 1'b0; wakeup_i = 1'b0;
    tick(2);
    n_checks++;
    if (obs !== exp_vec(S_ON)) begin
      n_errors++; $display("FAIL reset_state: got %b exp %b", obs, exp_vec(S_ON));
    end
    rst_ni = 1'b1;
    wakeup_i = 1'b1;
    tick(3);
    wakeup_i = 1'b0;
    n_checks++;
    if (obs !== exp_vec(S_ON)) begin
      n_errors++; $display("FAIL on_ignores_wakeup: got %b exp %b", obs, exp_vec(S_ON));
    end
    tick(20);
  endtask

  task automatic test_power_down;
    logic [3:0] st;
    power_off_req_i = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick(1);
      if (i == 0) power_off_req_i = 1'b0;
      st = (i < 2) ? S_CLK_OFF : (i < 4) ? S_ISO_ON : (i < 6) ? S_RST_ON :
           (i < 24) ? S_SW_OFF_WAIT : S_OFF;
      n_checks++;
      if (obs !== exp_vec(st)) begin
        n_errors++; $display("FAIL pd_cycle%0d: got %b exp %b", i, obs, exp_vec(st));
      end
    end
    power_off_req_i = 1'b1;
    tick(2);
    power_off_req_i = 1'b0;
    n_checks++;
    if (obs !== exp_vec(S_OFF)) begin
      n_errors++; $display("FAIL off_ignores_req: got %b exp %b", obs, exp_vec(S_OFF));
    end
  endtask

  task automatic test_power_up;
    logic [3:0] st;
    wakeup_i = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick(1);
      if (i == 0) wakeup_i = 1'b0;
      st = (i < 18) ? S_SW_ON_WAIT : (i < 20) ? S_RST_OFF : (i < 22) ? S_ISO_OFF :
           (i < 24) ? S_CLK_ON : S_ON;
      n_checks++;
      if (obs !== exp_vec(st)) begin
        n_errors++; $display("FAIL pu_cycle%0d: got %b exp %b", i, obs, exp_vec(st));
      end
    end
    tick(20);
  endtask

  task automatic test_both_requests;
    logic found;
    power_off_req_i = 1'b1; wakeup_i = 1'b1;
    tick(1);
    power_off_req_i = 1'b0; wakeup_i = 1'b0;
    n_checks++;
    if (obs !== exp_vec(S_CLK_OFF)) begin
      n_errors++; $display("FAIL both_in_on: got %b exp %b", obs, exp_vec(S_CLK_OFF));
    end
    tick(2);
    n_checks++;
    if (obs !== exp_vec(S_ISO_ON)) begin
      n_errors++; $display("FAIL iso_on_entry: got %b exp %b", obs, exp_vec(S_ISO_ON));
    end
    power_off_req_i = 1'b1; wakeup_i = 1'b1;
    tick(1);
    power_off_req_i = 1'b0; wakeup_i = 1'b0;
    n_checks++;
    if (obs !== exp_vec(S_ISO_ON)) begin
      n_errors++; $display("FAIL iso_on_toggle: got %b exp %b", obs, exp_vec(S_ISO_ON));
    end
    tick(1);
    n_checks++;
    if (obs !== exp_vec(S_RST_ON)) begin
      n_errors++; $display("FAIL iso_on_advance: got %b exp %b", obs, exp_vec(S_RST_ON));
    end
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick(1);
      if (state_o === S_OFF) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_errors++; $display("FAIL reach_off: got state %0d exp %0d", state_o, S_OFF);
    end
    tick(2);
    power_off_req_i = 1'b1; wakeup_i = 1'b1;
    tick(1);
    power_off_req_i = 1'b0; wakeup_i = 1'b0;
    n_checks++;
    if (obs !== exp_vec(S_SW_ON_WAIT)) begin
      n_errors++; $display("FAIL both_in_off: got %b exp %b", obs, exp_vec(S_SW_ON_WAIT));
    end
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick(1);
      if (state_o === S_ON) found = 1'b1;
    end
    n_checks++;
    if (!found || obs !== exp_vec(S_ON)) begin
      n_errors++; $display("FAIL reach_on: got %b exp %b", obs, exp_vec(S_ON));
    end
    tick(20);
  endtask

  task automatic test_reset_mid;
    power_off_req_i = 1'b1;
    tick(1);
    power_off_req_i = 1'b0;
    tick(4);
    n_checks++;
    if (obs !== exp_vec(S_RST_ON)) begin
      n_errors++; $display("FAIL mid_rst_on: got %b exp %b", obs, exp_vec(S_RST_ON));
    end
    rst_ni = 1'b0;
    tick(1);
    rst_ni = 1'b1;
    n_checks++;
    if (obs !== exp_vec(S_ON)) begin
      n_errors++; $display("FAIL mid_reset: got %b exp %b", obs, exp_vec(S_ON));
    end
    tick(1);
    n_checks++;
    if (obs !== exp_vec(S_ON)) begin
      n_errors++; $display("FAIL mid_reset_hold: got %b exp %b", obs, exp_vec(S_ON));
    end
  endtask

  task automatic test_fault;
    force_ack0 = 1'b1;
    power_off_req_i = 1'b1;
    for (int i = 0; i < 39; i++) begin
      tick(1);
      if (i == 37) begin
        n_checks++;
        if (obs !== exp_vec(S_SW_OFF_WAIT)) begin
          n_errors++; $display("FAIL pre_fault: got %b exp %b", obs, exp_vec(S_SW_OFF_WAIT));
        end
      end
    end
    n_checks++;
    if (obs !== exp_vec(S_FAULT)) begin
      n_errors++; $display("FAIL fault_entry: got %b exp %b", obs, exp_vec(S_FAULT));
    end
    power_off_req_i = 1'b0;
    wakeup_i = 1'b1;
    force_ack0 = 1'b0;
    tick(5);
    n_checks++;
    if (obs !== exp_vec(S_FAULT)) begin
      n_errors++; $display("FAIL fault_sticky: got %b exp %b", obs, exp_vec(S_FAULT));
    end
    wakeup_i = 1'b0;
    rst_ni = 1'b0;
    tick(1);
    rst_ni = 1'b1;
    n_checks++;
    if (obs !== exp_vec(S_ON)) begin
      n_errors++; $display("FAIL fault_reset: got %b exp %b", obs, exp_vec(S_ON));
    end
  endtask

  initial begin
    test_reset;
    test_power_down;
    test_power_up;
    test_both_requests;
    test_reset_mid;
    test_fault;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, state %0d", state_o);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
